// File: rtl/led_slot_arbiter.sv
// rtl/led_slot_arbiter.sv - round-robin time-slot arbiter driving a shared LED one-hot decoder
module led_slot_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_idx,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [2:0]             switch,
  output logic [2:0]             enable,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  // A zero-length gap would give a zero-width counter; keep one bit so the
  // register always exists (it is simply never loaded in that case).
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [HW-1:0]   cnt;
  logic [GW-1:0]   gcnt;

  logic [IW-1:0]       win;
  logic [NUM_REQ-1:0]  win_oh;
  logic                found;
  logic [IW-1:0]       next_ptr;

  // Round-robin pick: first active request starting at ptr, wrapping around.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    win    = '0;
    win_oh = '0;
    found  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found      = 1'b1;
        win        = jj;
        win_oh[jj] = 1'b1;
      end
    end
  end

  // Next pointer position: one past the requester that just finished.
  always_comb begin
    next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  // Slot sequencer: arbitrate in IDLE, hold the decoder, then blank it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= '0;
      done   <= '0;
      switch <= 3'd0;
      enable <= 3'd0;
      busy   <= 1'b0;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      gcnt   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= win_oh;
            owner  <= win;
            switch <= req_idx[3*win +: 3];
            enable <= 3'd4;
            busy   <= 1'b1;
            cnt    <= HW'(HOLD_CYCLES - 1);
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            done   <= grant;
            grant  <= '0;
            enable <= 3'd0;
            ptr    <= next_ptr;
            if (GAP_CYCLES > 0) begin
              gcnt  <= GW'(GAP_CYCLES - 1);
              state <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (gcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          enable <= 3'd0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
